// File: rtl/inv_mix_columns_seq.sv
// Sequential AES-128 InvMixColumns stage for the inverse-round datapath.
// Accepts a 128-bit state over valid/ready and transforms one 32-bit column per
// clock through a single shared column datapath. It then holds the result until
// downstream accepts it.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  upstream offers in_data
//   in_ready  block can accept a state (registered)
//   in_data   input state, column-major; byte 0 = [127:120], byte 15 = [7:0]
//   out_valid out_data holds a complete result (registered)
//   out_ready downstream accepts out_data
//   out_data  InvMixColumns(in_data), same byte layout
//   busy      high in any state other than idle (registered)
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state_q;
  logic [1:0]   col_q;
  logic [127:0] src_q;
  logic [127:0] res_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {0E*x, 0B*x, 0D*x, 09*x}, sharing the x2/x4/x8 doubling chain.
  function automatic logic [31:0] mul_set(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x};
  endfunction

  // Column c occupies bits [127-32c -: 32]; the base (3-c)*32 is {~c, 5'b0}.
  logic [6:0]  col_base;
  logic [31:0] col_src;
  logic [31:0] col_res;
  logic [31:0] m0, m1, m2, m3;

  always_comb begin
    col_base = {~col_q, 5'b00000};
    col_src  = src_q[col_base +: 32];
    m0 = mul_set(col_src[31:24]);
    m1 = mul_set(col_src[23:16]);
    m2 = mul_set(col_src[15:8]);
    m3 = mul_set(col_src[7:0]);
    // Field order in mul_set: [31:24]=0E, [23:16]=0B, [15:8]=0D, [7:0]=09.
    col_res[31:24] = m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0];
    col_res[23:16] = m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8];
    col_res[15:8]  = m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16];
    col_res[7:0]   = m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24];
  end

  // Handshake flags are computed alongside the state transition so that every
  // output is a plain flop; in_ready stays low for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= 2'd0;
      src_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            src_q      <= in_data;
            col_q      <= 2'd0;
            state_q    <= StBusy;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        StBusy: begin
          res_q[col_base +: 32] <= col_res;
          col_q                 <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = res_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] V2 = 128'hc6c6c6c6_c6c6c6c6_01010101_00000000;

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Reference model: generic GF(2^8) multiply and a circulant 4x4 matrix per column.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] apply_matrix(input logic [127:0] s, input logic [7:0] c0,
                                                 input logic [7:0] c1, input logic [7:0] c2,
                                                 input logic [7:0] c3);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] r;
    m[0] = c0; m[1] = c1; m[2] = c2; m[3] = c3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(m[(j - row + 4) % 4], s[127 - 8 * (4 * c + j) -: 8]);
        r[127 - 8 * (4 * c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
    return apply_matrix(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    return apply_matrix(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b busy=%b ready=%b expected 0 0 0",
               out_valid, busy, in_ready);
    end
    checks++;
    if (out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    int n;
    out_ready = 1'b1; in_data = V1; in_valid = 1'b1;
    tick();  // accept edge
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b expected 1", busy);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL single_latency: got %0d expected 4", n);
    end
    checks++;
    if (out_data !== E1) begin
      errors++;
      $display("FAIL single_data: got %h expected %h", out_data, E1);
    end
    tick();  // transfer edge
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_data = V1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== E1) begin
      errors++;
      $display("FAIL bp_first: got valid=%b data=%h expected 1 %h", out_valid, out_data, E1);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== E1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h expected 1 0 %h",
                 i, out_valid, in_ready, out_data, E1);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int           cyc;
    int           nacc;
    int           nres;
    int           acc_cyc [2];
    logic [127:0] res [2];
    logic         acc_now;
    logic         xfer;
    cyc = 0; nacc = 0; nres = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; res[0] = '0; res[1] = '0;
    out_ready = 1'b1; in_data = V1; in_valid = 1'b1;
    while (nres < 2 && cyc < 40) begin
      acc_now = in_valid && in_ready;
      xfer    = out_valid && out_ready;
      if (xfer) begin
        if (nres < 2) res[nres] = out_data;
        nres++;
      end
      if (acc_now) begin
        if (nacc < 2) acc_cyc[nacc] = cyc;
        nacc++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (nacc == 1) in_data = V2;
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nres !== 2 || nacc !== 2) begin
      errors++;
      $display("FAIL b2b_count: got results=%0d accepts=%0d expected 2 2", nres, nacc);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] !== 6) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d expected 6", acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (res[0] !== E1) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", res[0], E1);
    end
    checks++;
    if (res[1] !== V2) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", res[1], V2);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic         seen;
    logic [127:0] r;
    int           n;
    out_ready = 1'b1; in_data = V1; in_valid = 1'b1;
    tick();  // accept
    in_valid = 1'b0;
    tick();  // column 0
    tick();  // column 1
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL midrst_clear: got valid=%b busy=%b data=%h expected 0 0 0",
               out_valid, busy, out_data);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: got valid_seen=%b ready=%b expected 0 1", seen, in_ready);
    end
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_data = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4 || out_data !== ref_inv_mix(r)) begin
      errors++;
      $display("FAIL midrst_next: got lat=%0d data=%h expected 4 %h", n, out_data,
               ref_inv_mix(r));
    end
    tick();
  endtask

  task automatic test_random();
    logic [127:0] q_in[$];
    logic [127:0] src;
    logic         acc;
    logic         xfer;
    int           n_done;
    int           cycles;
    n_done = 0; cycles = 0; in_valid = 1'b0;
    while (n_done < 1000 && cycles < 40000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (acc) q_in.push_back(in_data);
      if (xfer) begin
        checks++;
        if (q_in.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious: got output %h expected none", out_data);
        end else begin
          src = q_in.pop_front();
          if (out_data !== ref_inv_mix(src)) begin
            errors++;
            $display("FAIL rnd_data[%0d]: got %h expected %h", n_done, out_data,
                     ref_inv_mix(src));
          end
          checks++;
          if (ref_mix(out_data) !== src) begin
            errors++;
            $display("FAIL rnd_roundtrip[%0d]: got %h expected %h", n_done,
                     ref_mix(out_data), src);
          end
        end
        n_done++;
      end
      tick();
      cycles++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_done !== 1000) begin
      errors++;
      $display("FAIL rnd_timeout: got %0d results expected 1000", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
